// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between integer execute (port 0)
// and address generation (port 1). Operands and result are registered, and both sides use valid/ready handshakes.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req_op0,
    input  logic [OPW-1:0]   req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] alu_d1,
    output logic [WIDTH-1:0] alu_d2,
    output logic [OPW-1:0]   alu_control,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic   last_grant;
    logic   owner;
    logic   grant;
    logic   accept;
    logic   rsp_done;

    // A lone requester always wins; when both request, the port not served last time wins.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11)
            grant = ~last_grant;
        else if (req_valid == 2'b10)
            grant = 1'b1;
    end

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready  = grant ? 2'b10 : 2'b01;
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (rsp_ready[owner]) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // The ALU operand registers hold their values between requests so the ALU inputs stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            alu_d1      <= '0;
            alu_d2      <= '0;
            alu_control <= '0;
            rsp_valid   <= 2'b00;
            rsp_result  <= '0;
        end else begin
            if (accept) begin
                alu_d1      <= grant ? req_a1  : req_a0;
                alu_d2      <= grant ? req_b1  : req_b0;
                alu_control <= grant ? req_op1 : req_op0;
                owner       <= grant;
                last_grant  <= grant;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_valid  <= owner ? 2'b10 : 2'b01;
            end
            if (rsp_done)
                rsp_valid <= 2'b00;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter. A behavioural ALU drives alu_result, and the
// expected grant order and results come from the arbitration rules applied at transaction level.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0 = '0, req_op1 = '0;
    logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp_result;
    logic [31:0] alu_d1, alu_d2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;

    int tests = 0;
    int fails = 0;
    logic lg = 1'b1;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return {31'b0, $signed(a) < $signed(b)};
            4'd9:    return {31'b0, a < b};
            4'd10:   return ~(a | b);
            4'd11:   return a;
            4'd12:   return b;
            4'd13:   return ~a;
            4'd14:   return a & ~b;
            default: return ~(a ^ b);
        endcase
    endfunction

    assign alu_result = alu_ref(alu_control, alu_d1, alu_d2);

    alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_control(alu_control),
        .alu_result(alu_result)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        rst = 1'b0;
        lg = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if (rsp_valid !== 2'b00 || rsp_result !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_rsp: rsp_valid=%b rsp_result=%h, wanted 00/0", rsp_valid, rsp_result);
        end
        tests++;
        if (alu_d1 !== 32'h0 || alu_d2 !== 32'h0 || alu_control !== 4'h0) begin
            fails++;
            $display("[TB] FAIL reset_alu: d1=%h d2=%h ctl=%h, wanted zeros", alu_d1, alu_d2, alu_control);
        end
        tests++;
        if (req_ready !== 2'b00) begin
            fails++;
            $display("[TB] FAIL reset_ready: req_ready=%b, wanted 00", req_ready);
        end
    endtask

    task automatic test_single_op();
        req_a0 = 32'h10101010; req_b0 = 32'h01010101; req_op0 = 4'b0000;
        req_valid = 2'b01;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("[TB] FAIL single_accept: req_ready=%b, wanted 01", req_ready);
        end
        tick();
        lg = 1'b0;
        req_valid = 2'b00;
        #1;
        tests++;
        if (alu_control !== 4'h0 || alu_d1 !== 32'h10101010 || alu_d2 !== 32'h01010101 || rsp_valid !== 2'b00) begin
            fails++;
            $display("[TB] FAIL single_exec: ctl=%h d1=%h d2=%h rsp_valid=%b", alu_control, alu_d1, alu_d2, rsp_valid);
        end
        tick();
        tests++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'h11111111) begin
            fails++;
            $display("[TB] FAIL single_rsp: rsp_valid=%b rsp_result=%h, wanted 01/11111111", rsp_valid, rsp_result);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        #1;
        tests++;
        if (rsp_valid !== 2'b00) begin
            fails++;
            $display("[TB] FAIL single_done: rsp_valid=%b, wanted 00", rsp_valid);
        end
    endtask

    task automatic test_tie_break();
        logic [31:0] exp;
        logic [1:0]  oh;
        do_reset();
        req_op1 = 4'b0001; req_a1 = 32'h10101010; req_b1 = 32'h01010101;
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            req_op0 = 4'($urandom_range(0, 15));
            req_a0 = $urandom; req_b0 = $urandom;
            req_valid = 2'b11;
            oh = (i % 2 == 1) ? 2'b10 : 2'b01;
            exp = (i % 2 == 1) ? 32'h0F0F0F0F : alu_ref(req_op0, req_a0, req_b0);
            #1;
            tests++;
            if (req_ready !== oh) begin
                fails++;
                $display("[TB] FAIL tie_grant%0d: req_ready=%b, wanted %b", i, req_ready, oh);
            end
            tick();
            tick();
            tests++;
            if (rsp_valid !== oh || rsp_result !== exp) begin
                fails++;
                $display("[TB] FAIL tie_rsp%0d: rsp_valid=%b rsp_result=%h, wanted %b/%h", i, rsp_valid, rsp_result, oh, exp);
            end
            tick();
        end
        lg = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        logic [31:0] held;
        req_op0 = 4'd4; req_a0 = $urandom; req_b0 = $urandom;
        exp = alu_ref(req_op0, req_a0, req_b0);
        req_valid = 2'b01;
        tick();
        lg = 1'b0;
        tick();
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (rsp_valid !== 2'b01 || rsp_result !== exp || req_ready !== 2'b00) begin
                fails++;
                $display("[TB] FAIL bp_stall%0d: rsp_valid=%b rsp_result=%h req_ready=%b, wanted 01/%h/00",
                         i, rsp_valid, rsp_result, req_ready, exp);
            end
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        #1;
        tests++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
            fails++;
            $display("[TB] FAIL bp_idle: rsp_valid=%b req_ready=%b, wanted 00/10", rsp_valid, req_ready);
        end
        held = alu_d1;
        req_valid = 2'b00;
        tick();
        tests++;
        if (alu_d1 !== held || req_ready !== 2'b00) begin
            fails++;
            $display("[TB] FAIL bp_drop: alu_d1=%h req_ready=%b, wanted %h/00", alu_d1, req_ready, held);
        end
    endtask

    task automatic test_reset_exec();
        req_op1 = 4'd3; req_a1 = 32'hDEADBEEF; req_b1 = 32'h12345678;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lg = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (rsp_valid !== 2'b00 || alu_d1 !== 32'h0 || alu_d2 !== 32'h0 || alu_control !== 4'h0) begin
                fails++;
                $display("[TB] FAIL rst_exec%0d: rsp_valid=%b d1=%h d2=%h ctl=%h, wanted all zero",
                         i, rsp_valid, alu_d1, alu_d2, alu_control);
            end
            tick();
        end
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("[TB] FAIL rst_regrant: req_ready=%b, wanted 01", req_ready);
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_op_sweep();
        logic [31:0] exp;
        req_a1 = 32'h8000_00F3; req_b1 = 32'h0000_0005;
        rsp_ready = 2'b11;
        req_valid = 2'b10;
        for (int op = 0; op < 16; op++) begin
            req_op1 = 4'(op);
            exp = alu_ref(4'(op), req_a1, req_b1);
            #1;
            tests++;
            if (req_ready !== 2'b10) begin
                fails++;
                $display("[TB] FAIL sweep_grant%0d: req_ready=%b, wanted 10", op, req_ready);
            end
            tick();
            tick();
            tests++;
            if (rsp_valid !== 2'b10 || rsp_result !== exp) begin
                fails++;
                $display("[TB] FAIL sweep_rsp%0d: rsp_valid=%b rsp_result=%h, wanted 10/%h", op, rsp_valid, rsp_result, exp);
            end
            tick();
        end
        lg = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
    endtask

    task automatic test_random();
        logic [1:0]  v;
        logic [1:0]  r;
        logic [1:0]  oh;
        logic        g;
        logic [31:0] ea, eb, exp, held;
        logic [3:0]  eop;
        int          stall;
        for (int it = 0; it < 40; it++) begin
            v = 2'($urandom_range(0, 3));
            req_op0 = 4'($urandom_range(0, 15)); req_a0 = $urandom; req_b0 = $urandom;
            req_op1 = 4'($urandom_range(0, 15)); req_a1 = $urandom; req_b1 = $urandom;
            req_valid = v;
            #1;
            if (v == 2'b00) begin
                held = alu_d1;
                tests++;
                if (req_ready !== 2'b00) begin
                    fails++;
                    $display("[TB] FAIL rnd_noreq%0d: req_ready=%b, wanted 00", it, req_ready);
                end
                tick();
                tests++;
                if (alu_d1 !== held) begin
                    fails++;
                    $display("[TB] FAIL rnd_hold%0d: alu_d1=%h, wanted %h", it, alu_d1, held);
                end
                continue;
            end
            g   = (v == 2'b11) ? ~lg : (v == 2'b10);
            oh  = g ? 2'b10 : 2'b01;
            ea  = g ? req_a1 : req_a0;
            eb  = g ? req_b1 : req_b0;
            eop = g ? req_op1 : req_op0;
            exp = alu_ref(eop, ea, eb);
            tests++;
            if (req_ready !== oh) begin
                fails++;
                $display("[TB] FAIL rnd_grant%0d: req_ready=%b, wanted %b", it, req_ready, oh);
            end
            tick();
            lg = g;
            req_valid = 2'($urandom_range(0, 3));
            req_a0 = $urandom; req_a1 = $urandom;
            #1;
            tests++;
            if (alu_d1 !== ea || alu_d2 !== eb || alu_control !== eop || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
                fails++;
                $display("[TB] FAIL rnd_exec%0d: d1=%h d2=%h ctl=%h ready=%b rv=%b, wanted %h/%h/%h/00/00",
                         it, alu_d1, alu_d2, alu_control, req_ready, rsp_valid, ea, eb, eop);
            end
            tick();
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                r = 2'($urandom_range(0, 3));
                r[g] = 1'b0;
                rsp_ready = r;
                #1;
                tests++;
                if (rsp_valid !== oh || rsp_result !== exp || req_ready !== 2'b00) begin
                    fails++;
                    $display("[TB] FAIL rnd_stall%0d: rv=%b res=%h ready=%b, wanted %b/%h/00",
                             it, rsp_valid, rsp_result, req_ready, oh, exp);
                end
                tick();
            end
            r = 2'($urandom_range(0, 3));
            r[g] = 1'b1;
            rsp_ready = r;
            #1;
            tests++;
            if (rsp_valid !== oh || rsp_result !== exp) begin
                fails++;
                $display("[TB] FAIL rnd_rsp%0d: rv=%b res=%h, wanted %b/%h", it, rsp_valid, rsp_result, oh, exp);
            end
            tick();
            req_valid = 2'b00;
            rsp_ready = 2'b00;
            #1;
            tests++;
            if (rsp_valid !== 2'b00) begin
                fails++;
                $display("[TB] FAIL rnd_done%0d: rsp_valid=%b, wanted 00", it, rsp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_tie_break();
        test_backpressure();
        test_reset_exec();
        test_op_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
